// File: rtl/gpu_pkg.sv
// Shared types and defaults for the rectangle renderer.
package gpu_pkg;

    // Geometry and bus-width defaults
    localparam int DEF_SCREEN_W = 320;
    localparam int DEF_SCREEN_H = 240;
    localparam int DEF_RECT_W   = 16;
    localparam int DEF_RECT_H   = 16;
    localparam int DEF_ADDR_W   = 18;
    localparam int DEF_DATA_W   = 16;

    // Colour constants
    localparam logic [15:0] BG_COLOR = 16'h0000;
    localparam logic [15:0] FG_COLOR = 16'hF800;

    // Seven-segment pattern for digit 0, active-low {g..a}
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    // Renderer sequencing
    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ERASE = 3'd2,
        ST_MOVE  = 3'd3,
        ST_DRAW  = 3'd4
    } state_t;

endpackage

// File: rtl/gpu_hex.sv
// Nibble to active-low seven-segment decoder, bit order {g,f,e,d,c,b,a}.
module hex_to_7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure lookup of the hex glyph for one nibble
    always_comb begin
        seg = 7'b1111111;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/gpu.sv
// Rectangle renderer: clears the frame buffer, then per frame erases,
// bounces and redraws a sprite, writing only during video blanking.
//
// SRAM write interface: O_GPU_WRITE is a one-cycle strobe qualifying
// O_GPU_ADDR/O_GPU_DATA (one word per high cycle, no back-pressure).
// I_VIDEO_ON acts as the inverse of a grant: a pixel is only issued on a
// cycle that sampled I_VIDEO_ON=0, otherwise the iterator holds in place.
module gpu
    import gpu_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int RECT_W   = DEF_RECT_W,
    parameter int RECT_H   = DEF_RECT_H,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    input  logic              I_VIDEO_ON,
    input  logic [DATA_W-1:0] I_GPU_DATA,
    output logic [DATA_W-1:0] O_GPU_DATA,
    output logic [ADDR_W-1:0] O_GPU_ADDR,
    output logic              O_GPU_READ,
    output logic              O_GPU_WRITE,
    output logic [6:0]        O_HEX0,
    output logic [6:0]        O_HEX1,
    output logic [6:0]        O_HEX2,
    output logic [6:0]        O_HEX3,
    output state_t            dbg_state
);

    localparam int X_W = $clog2(SCREEN_W);
    localparam int Y_W = $clog2(SCREEN_H);
    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - RECT_W);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - RECT_H);

    state_t            state, next_state;
    logic              vid_d;
    logic [X_W-1:0]    x, col, col_max, base_x, pix_x;
    logic [Y_W-1:0]    y, row, row_max, base_y, pix_y;
    logic              dx_neg, dy_neg;
    logic [15:0]       frame_cnt;
    logic              write_state, step, last_px;
    logic [DATA_W-1:0] color;
    logic [ADDR_W-1:0] pix_addr;
    logic [6:0]        seg_w [4];
    logic              unused_rd_data;

    // Read path is reserved; the renderer never reads the frame buffer
    assign unused_rd_data = ^I_GPU_DATA;
    assign O_GPU_READ     = 1'b0;
    assign dbg_state      = state;

    // Pixel position of the iterator and its linear word address
    assign pix_x    = base_x + col;
    assign pix_y    = base_y + row;
    assign pix_addr = ADDR_W'(pix_y) * ADDR_W'(SCREEN_W) + ADDR_W'(pix_x);

    for (genvar i = 0; i < 4; i++) begin : g_hex
        hex_to_7seg u_hex (
            .nibble (frame_cnt[4*i +: 4]),
            .seg    (seg_w[i])
        );
    end

    // State register
    always_ff @(posedge I_CLK) begin
        if (I_RST) state <= ST_CLEAR;
        else       state <= next_state;
    end

    // Next state plus iterator window/colour for the current pass
    always_comb begin
        next_state  = state;
        write_state = 1'b0;
        color       = BG_COLOR;
        col_max     = X_W'(RECT_W - 1);
        row_max     = Y_W'(RECT_H - 1);
        base_x      = x;
        base_y      = y;
        case (state)
            ST_CLEAR: begin
                write_state = 1'b1;
                col_max     = X_W'(SCREEN_W - 1);
                row_max     = Y_W'(SCREEN_H - 1);
                base_x      = '0;
                base_y      = '0;
            end
            ST_ERASE: write_state = 1'b1;
            ST_DRAW: begin
                write_state = 1'b1;
                color       = FG_COLOR;
            end
            default: ;
        endcase
        step    = write_state && !I_VIDEO_ON;
        last_px = (col == col_max) && (row == row_max);
        case (state)
            ST_CLEAR: if (step && last_px) next_state = ST_WAIT;
            ST_WAIT:  if (vid_d && !I_VIDEO_ON) next_state = ST_ERASE;
            ST_ERASE: if (step && last_px) next_state = ST_MOVE;
            ST_MOVE:  next_state = ST_DRAW;
            ST_DRAW:  if (step && last_px) next_state = ST_WAIT;
            default:  next_state = ST_CLEAR;
        endcase
    end

    // Datapath: bus outputs, iterator, sprite motion, frame counter, HEX
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            vid_d       <= 1'b0;
            O_GPU_WRITE <= 1'b0;
            O_GPU_ADDR  <= '0;
            O_GPU_DATA  <= '0;
            col         <= '0;
            row         <= '0;
            x           <= '0;
            y           <= '0;
            dx_neg      <= 1'b0;
            dy_neg      <= 1'b0;
            frame_cnt   <= '0;
            O_HEX0      <= SEG_ZERO;
            O_HEX1      <= SEG_ZERO;
            O_HEX2      <= SEG_ZERO;
            O_HEX3      <= SEG_ZERO;
        end else begin
            vid_d       <= I_VIDEO_ON;
            O_GPU_WRITE <= step;
            if (step) begin
                O_GPU_ADDR <= pix_addr;
                O_GPU_DATA <= color;
                // Row-major walk, x fastest; wraps to 0 for the next pass
                if (col == col_max) begin
                    col <= '0;
                    row <= (row == row_max) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            // Bounce: reverse direction before stepping when at a wall
            if (state == ST_MOVE) begin
                if (!dx_neg && x == X_MAX) begin
                    dx_neg <= 1'b1;
                    x      <= x - 1'b1;
                end else if (dx_neg && x == '0) begin
                    dx_neg <= 1'b0;
                    x      <= x + 1'b1;
                end else begin
                    x <= dx_neg ? x - 1'b1 : x + 1'b1;
                end
                if (!dy_neg && y == Y_MAX) begin
                    dy_neg <= 1'b1;
                    y      <= y - 1'b1;
                end else if (dy_neg && y == '0) begin
                    dy_neg <= 1'b0;
                    y      <= y + 1'b1;
                end else begin
                    y <= dy_neg ? y - 1'b1 : y + 1'b1;
                end
            end
            if (state == ST_DRAW && step && last_px) frame_cnt <= frame_cnt + 16'd1;
            O_HEX0 <= seg_w[0];
            O_HEX1 <= seg_w[1];
            O_HEX2 <= seg_w[2];
            O_HEX3 <= seg_w[3];
        end
    end

endmodule

// File: tb/tb_gpu.sv
// Bench for gpu: reduced, non-square geometry so bounces and full clears
// fit in a short run; expected writes come from a frame-level model.
module tb_gpu;
    import gpu_pkg::*;

    localparam int SW = 40;
    localparam int SH = 30;
    localparam int RW = 8;
    localparam int RH = 6;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int XMAX = SW - RW;
    localparam int YMAX = SH - RH;
    localparam int AREA = RW * RH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          video_on = 1'b0;
    logic [DW-1:0] gpu_rd = '0;
    logic [DW-1:0] gpu_data;
    logic [AW-1:0] gpu_addr;
    logic          gpu_read, gpu_write;
    logic [6:0]    hex0, hex1, hex2, hex3;
    state_t        dbg_state;

    gpu #(
        .SCREEN_W(SW), .SCREEN_H(SH), .RECT_W(RW), .RECT_H(RH),
        .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .I_CLK       (clk),
        .I_RST       (rst),
        .I_VIDEO_ON  (video_on),
        .I_GPU_DATA  (gpu_rd),
        .O_GPU_DATA  (gpu_data),
        .O_GPU_ADDR  (gpu_addr),
        .O_GPU_READ  (gpu_read),
        .O_GPU_WRITE (gpu_write),
        .O_HEX0      (hex0),
        .O_HEX1      (hex1),
        .O_HEX2      (hex2),
        .O_HEX3      (hex3),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] tab [16];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return tab[n];
    endfunction

    // ---------------- scoreboard ----------------
    logic [AW+DW-1:0] exp_q[$];
    logic             vid_at_edge = 1'b0;
    bit               mon_en = 1'b0;
    int               fg_total = 0;
    logic [AW-1:0]    first_fg = '0;

    always @(posedge clk) vid_at_edge <= video_on;

    always @(negedge clk) begin
        if (mon_en) begin
            if (vid_at_edge) check("stall_write", gpu_write, 1'b0);
            if (gpu_write) begin
                check("read_strobe", gpu_read, 1'b0);
                if (exp_q.size() == 0) check("extra_write_qsize", exp_q.size(), 1);
                else check("write_addr_data", {gpu_addr, gpu_data}, exp_q.pop_front());
                if (gpu_data == FG_COLOR) begin
                    if (fg_total % AREA == 0) first_fg <= gpu_addr;
                    fg_total <= fg_total + 1;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    int          mx, my, mdx, mdy;
    logic [15:0] mcnt;

    task automatic model_reset();
        mx = 0; my = 0; mdx = 1; mdy = 1; mcnt = '0;
    endtask

    task automatic push_rect(input int x0, input int y0, input logic [DW-1:0] c);
        for (int r = 0; r < RH; r++)
            for (int k = 0; k < RW; k++)
                exp_q.push_back({AW'((y0 + r) * SW + x0 + k), c});
    endtask

    task automatic push_clear();
        for (int a = 0; a < SW * SH; a++) exp_q.push_back({AW'(a), BG_COLOR});
    endtask

    task automatic model_frame();
        push_rect(mx, my, BG_COLOR);
        if (mx + mdx < 0 || mx + mdx > XMAX) mdx = -mdx;
        if (my + mdy < 0 || my + mdy > YMAX) mdy = -mdy;
        mx += mdx;
        my += mdy;
        push_rect(mx, my, FG_COLOR);
        mcnt++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic start_frame();
        tick($urandom_range(1, 6));
        video_on = 1'b1;
        tick($urandom_range(1, 4));
        video_on = 1'b0;
    endtask

    // Waits for the expected queue to empty, optionally stalling with I_VIDEO_ON
    task automatic drain(input string tag, input int budget, input int stall_at, input bit rnd);
        int  cyc = 0;
        bit  stalled = 1'b0;
        int  n;
        while (exp_q.size() > 0 && cyc < budget) begin
            tick();
            cyc++;
            if (!stalled && exp_q.size() == stall_at) begin
                stalled  = 1'b1;
                video_on = 1'b1;
                tick(10);
                cyc += 10;
                video_on = 1'b0;
            end else if (rnd && exp_q.size() > 5 && $urandom_range(0, 15) == 0) begin
                n = $urandom_range(1, 6);
                video_on = 1'b1;
                tick(n);
                cyc += n;
                video_on = 1'b0;
            end
        end
        check({tag, "_drain_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_hex(input string tag, input logic [15:0] cnt);
        tick(2);
        check({tag, "_hex0"}, hex0, seg(cnt[3:0]));
        check({tag, "_hex1"}, hex1, seg(cnt[7:4]));
        check({tag, "_hex2"}, hex2, seg(cnt[11:8]));
        check({tag, "_hex3"}, hex3, seg(cnt[15:12]));
    endtask

    task automatic run_frame(input string tag, input int stall_at, input bit rnd);
        int fg0;
        int px, pdx;
        fg0 = fg_total;
        px  = mx;
        pdx = mdx;
        model_frame();
        start_frame();
        drain(tag, 4000, stall_at, rnd);
        tick();
        check({tag, "_fg_count"}, fg_total - fg0, AREA);
        check({tag, "_first_fg"}, first_fg, AW'(my * SW + mx));
        if (pdx != mdx) check({tag, "_bounce_x"}, first_fg % SW, px - 1 + (pdx < 0 ? 2 : 0));
        check_hex(tag, mcnt);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        model_reset();
        rst = 1'b1;
        tick(3);
        check("rst_write", gpu_write, 1'b0);
        check("rst_read", gpu_read, 1'b0);
        check("rst_addr", gpu_addr, '0);
        check("rst_data", gpu_data, '0);
        check("rst_state", dbg_state, ST_CLEAR);
        check_hex("rst", 16'h0000);

        // Full clear with random blanking interruptions
        mon_en = 1'b1;
        push_clear();
        rst = 1'b0;
        drain("clear", 20000, -1, 1'b1);
        check_hex("clear", 16'h0000);
        check("clear_idle_state", dbg_state, ST_WAIT);
        tick(20);

        // First frame: sprite moves from (0,0) to (1,1)
        run_frame("frame1", -1, 1'b0);
        check("frame1_addr_41", first_fg, AW'(SW + 1));

        // Mid-DRAW stall of 10 cycles
        run_frame("frame2_stall", AREA / 2, 1'b0);

        // Random-stall frames through both wall bounces
        for (int f = 3; f <= 36; f++) begin
            run_frame($sformatf("frame%0d", f), -1, 1'b1);
            if (f == 25) check("y_bounce_223_equiv", first_fg / SW, YMAX - 1);
        end

        // Reset in the middle of ERASE
        model_frame();
        start_frame();
        for (int c = 0; c < 200 && exp_q.size() > 2 * AREA - 10; c++) tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("abort_write", gpu_write, 1'b0);
        check("abort_state", dbg_state, ST_CLEAR);
        check("abort_hex0", hex0, seg(4'h0));
        model_reset();
        push_clear();
        rst = 1'b0;
        drain("reclear", 20000, -1, 1'b0);
        check_hex("reclear", 16'h0000);
        run_frame("after_abort", -1, 1'b0);

        // Frame counter wrap
        force dut.frame_cnt = 16'hFFFF;
        tick();
        release dut.frame_cnt;
        check_hex("preset_ffff", 16'hFFFF);
        mcnt = 16'hFFFF;
        run_frame("wrap", -1, 1'b0);
        check("wrap_cnt_model", mcnt, 16'h0000 + (hex0 == seg(4'h0) ? 0 : 1));

        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
